// File: rtl/ef9345_cmd_seq_if.sv
// ef9345_cmd_seq_if: request/response handshake plus EF9345 multiplexed-bus pins.
interface ef9345_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [6:0]  req_mask;
  logic [55:0] req_args;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        bus_as;
  logic        bus_ds;
  logic        bus_rw;
  logic        bus_cs_;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic [7:0]  bus_din;
  modport master (
    input  req_valid, req_cmd, req_mask, req_args, bus_din,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output bus_as, bus_ds, bus_rw, bus_cs_, bus_dout, bus_oe
  );
  modport slave (
    output req_valid, req_cmd, req_mask, req_args, bus_din,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  bus_as, bus_ds, bus_rw, bus_cs_, bus_dout, bus_oe
  );
endinterface

// File: rtl/ef9345_cmd_seq.sv
// ef9345_cmd_seq: EF9345 Motorola-mode sequencer (arg writes, R0 command, busy poll, R1 readback).
// Define EF9345_SEQ_TIMEOUT_EN to bound polling at POLL_MAX status reads and report rsp_err.
module ef9345_cmd_seq #(
  parameter int         PHASE_CYC = 2,
  parameter logic [4:0] ADDR_HI   = 5'b00100,
  parameter int         BUSY_BIT  = 7
`ifdef EF9345_SEQ_TIMEOUT_EN
  , parameter int       POLL_MAX  = 255
`endif
) (
  input logic              clk_in,
  input logic              reset_,
  ef9345_cmd_seq_if.master sif
);
  localparam logic [2:0] IDLE = 3'd0, ARGS = 3'd1, CMD = 3'd2, POLL = 3'd3, RESULT = 3'd4, DONE = 3'd5;
  localparam int CW = PHASE_CYC > 1 ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] CMAX = CW'(PHASE_CYC - 1);
  logic [2:0]    st, nxt, ph, idx;
  logic [CW-1:0] cnt;
  logic [6:0]    m;
  logic [7:0]    cmd, arg, addr, rdata;
  logic [55:0]   args;
  logic          busy, act, rd, wrap, tmo;
  assign wrap = cnt == CMAX;
`ifdef EF9345_SEQ_TIMEOUT_EN
  logic [7:0] pcnt;
  logic       err;
  assign tmo = busy && pcnt == 8'(POLL_MAX - 1);
  assign sif.rsp_err = err;
  always_ff @(posedge clk_in or negedge reset_)
    if (!reset_) begin
      pcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (st == IDLE && sif.req_valid) err <= 1'b0;
      if (ph == 3'd5 && st == CMD) pcnt <= '0;
      if (ph == 3'd5 && st == POLL) begin
        pcnt <= pcnt + 8'd1;
        if (tmo) err <= 1'b1;
      end
    end
`else
  assign tmo = 1'b0;
  assign sif.rsp_err = 1'b0;
`endif
  // lowest pending mask bit selects the next argument register
  always_comb begin
    idx = '0;
    arg = '0;
    for (int i = 6; i >= 0; i--)
      if (m[i]) begin
        idx = 3'(i + 1);
        arg = args[8*i +: 8];
      end
    rd   = st == POLL || st == RESULT;
    act  = (st == ARGS || st == CMD || rd) && ph != 3'd5;
    addr = st == ARGS ? {ADDR_HI, idx} : st == CMD ? ({ADDR_HI, 3'b000} | 8'h08) : {ADDR_HI, 2'b00, st == RESULT};
    nxt  = st == ARGS ? ((m & (m - 7'd1)) == '0 ? CMD : ARGS) :
           st == CMD  ? POLL :
           st == POLL ? (busy ? (tmo ? DONE : POLL) : RESULT) : DONE;
  end
  assign sif.bus_cs_   = !act;
  assign sif.bus_as    = act && ph == 3'd0;
  assign sif.bus_ds    = act && ph == 3'd3;
  assign sif.bus_rw    = !(act && !rd && ph >= 3'd2);
  assign sif.bus_oe    = act && (ph < 3'd2 || !rd);
  assign sif.bus_dout  = !act ? 8'h00 : (ph < 3'd2 || rd) ? addr : (st == ARGS ? arg : cmd);
  assign sif.req_ready = st == IDLE;
  assign sif.rsp_valid = st == DONE;
  assign sif.rsp_data  = rdata;
  // ph 0..4 are ADR/LAT/SET/STB/HLD, ph 5 is the single idle cycle closing an access
  always_ff @(posedge clk_in or negedge reset_)
    if (!reset_) begin
      st    <= IDLE;
      ph    <= '0;
      cnt   <= '0;
      m     <= '0;
      cmd   <= '0;
      args  <= '0;
      busy  <= 1'b0;
      rdata <= '0;
    end else if (st == IDLE) begin
      if (sif.req_valid) begin
        st   <= sif.req_mask != '0 ? ARGS : CMD;
        m    <= sif.req_mask;
        cmd  <= sif.req_cmd;
        args <= sif.req_args;
        ph   <= '0;
        cnt  <= '0;
      end
    end else if (st == DONE) begin
      st <= IDLE;
    end else if (ph == 3'd5) begin
      st  <= nxt;
      ph  <= '0;
      cnt <= '0;
      if (st == ARGS) m <= m & (m - 7'd1);
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) ph <= ph + 3'd1;
      if (ph == 3'd3 && wrap && st == POLL) busy <= sif.bus_din[BUSY_BIT];
      if (ph == 3'd3 && wrap && st == RESULT) rdata <= sif.bus_din;
    end
endmodule

// File: tb/tb_ef9345_cmd_seq.sv
// tb_ef9345_cmd_seq: directed bench with a small EF9345 bus model logging every strobed access.
module tb_ef9345_cmd_seq;
  logic clk_in = 1'b0;
  logic reset_ = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0, busy_left = 0, viol = 0;
  logic [7:0] lat = 8'h00, r1_val = 8'h00;
  logic as_q = 1'b0, ds_q = 1'b0;
  logic       lg_rw[$];
  logic [7:0] lg_addr[$], lg_data[$], rsp_d[$];
  logic       rsp_e[$];
  int         as_cyc[$], rsp_cyc[$];

  ef9345_cmd_seq_if sif();

`ifdef EF9345_SEQ_TIMEOUT_EN
  ef9345_cmd_seq #(.PHASE_CYC(2), .POLL_MAX(4)) dut (.clk_in(clk_in), .reset_(reset_), .sif(sif));
`else
  ef9345_cmd_seq #(.PHASE_CYC(2)) dut (.clk_in(clk_in), .reset_(reset_), .sif(sif));
`endif

  always #5 clk_in = ~clk_in;

  assign sif.bus_din = lat == 8'h20 ? (busy_left > 0 ? 8'h80 : 8'h00) : lat == 8'h21 ? r1_val : 8'hFF;

  always @(negedge clk_in) begin
    cyc++;
    if (sif.bus_as && sif.bus_ds) viol++;
    if (sif.bus_as) lat = sif.bus_dout;
    if (sif.bus_as && !as_q) as_cyc.push_back(cyc);
    if (sif.bus_ds && !ds_q) begin
      if (sif.bus_cs_) viol++;
      lg_rw.push_back(sif.bus_rw);
      lg_addr.push_back(lat);
      lg_data.push_back(sif.bus_dout);
    end
    if (!sif.bus_ds && ds_q && sif.bus_rw && lat == 8'h20 && busy_left > 0) busy_left--;
    if (sif.rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_d.push_back(sif.rsp_data);
      rsp_e.push_back(sif.rsp_err);
    end
    as_q = sif.bus_as;
    ds_q = sif.bus_ds;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    lg_rw.delete(); lg_addr.delete(); lg_data.delete();
    as_cyc.delete(); rsp_cyc.delete(); rsp_d.delete(); rsp_e.delete();
  endtask

  task automatic send(input logic [7:0] c, input logic [6:0] mk, input logic [55:0] a);
    int n = 0;
    @(negedge clk_in);
    while (!sif.req_ready && n < 300) begin @(negedge clk_in); n++; end
    checks++;
    if (n >= 300) begin failures++; $display("FAIL send_ready_timeout got=0 exp=1"); end
    sif.req_valid = 1'b1; sif.req_cmd = c; sif.req_mask = mk; sif.req_args = a;
    @(negedge clk_in);
    sif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int k);
    int n = 0;
    while (rsp_cyc.size() < k && n < 3000) begin @(negedge clk_in); n++; end
    checks++;
    if (n >= 3000) begin failures++; $display("FAIL rsp_timeout got=%0d exp=%0d", rsp_cyc.size(), k); end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    int n = 0;
    sif.req_valid = 1'b0; sif.req_cmd = '0; sif.req_mask = '0; sif.req_args = '0;
    reset_ = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({sif.bus_as, sif.bus_ds, sif.bus_rw, sif.bus_cs_, sif.bus_oe, sif.bus_dout} !== 13'b0_0_1_1_0_00000000) begin
      failures++; $display("FAIL reset_bus got=%b exp=0011000000000", {sif.bus_as, sif.bus_ds, sif.bus_rw, sif.bus_cs_, sif.bus_oe, sif.bus_dout});
    end
    checks++;
    if ({sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.req_ready} !== 11'b0_00000000_0_1) begin
      failures++; $display("FAIL reset_rsp got=%b exp=00000000001", {sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.req_ready});
    end
    reset_ = 1'b1;
    clear_log();
    send(8'h80, 7'b0000001, 56'h11);
    while (!sif.bus_ds && n < 100) begin @(negedge clk_in); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL reset_wait_strobe got=0 exp=1"); end
    reset_ = 1'b0;
    #1;
    checks++;
    if ({sif.bus_as, sif.bus_ds, sif.bus_rw, sif.bus_cs_, sif.bus_oe, sif.bus_dout} !== 13'b0_0_1_1_0_00000000) begin
      failures++; $display("FAIL reset_mid_stb got=%b exp=0011000000000", {sif.bus_as, sif.bus_ds, sif.bus_rw, sif.bus_cs_, sif.bus_oe, sif.bus_dout});
    end
    @(negedge clk_in);
    reset_ = 1'b1;
    repeat (2) @(negedge clk_in);
    checks++;
    if (sif.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sif.req_ready); end
    repeat (40) @(negedge clk_in);
    checks++;
    if (rsp_cyc.size() != 0 || lg_addr.size() != 1) begin
      failures++; $display("FAIL reset_dropped rsp=%0d strobes=%0d exp rsp=0 strobes=1", rsp_cyc.size(), lg_addr.size());
    end
  endtask

  task automatic test_args_write();
    logic [16:0] exp[5];
    exp = '{{1'b0, 8'h21, 8'h11}, {1'b0, 8'h23, 8'h33}, {1'b0, 8'h28, 8'h80}, {1'b1, 8'h20, 8'h00}, {1'b1, 8'h21, 8'h00}};
    clear_log(); busy_left = 0; r1_val = 8'h3C;
    send(8'h80, 7'b0000101, 56'h33_00_11);
    wait_rsp(1);
    checks++;
    if (lg_addr.size() != 5) begin failures++; $display("FAIL args_count got=%0d exp=5", lg_addr.size()); end
    for (int i = 0; i < 5 && i < lg_addr.size(); i++) begin
      checks++;
      if ({lg_rw[i], lg_addr[i], lg_rw[i] ? 8'h00 : lg_data[i]} !== exp[i]) begin
        failures++; $display("FAIL args_access%0d got=%h exp=%h", i, {lg_rw[i], lg_addr[i], lg_rw[i] ? 8'h00 : lg_data[i]}, exp[i]);
      end
    end
    for (int i = 1; i < as_cyc.size() && i < 5; i++) begin
      checks++;
      if (as_cyc[i] - as_cyc[i-1] != 11) begin failures++; $display("FAIL args_len%0d got=%0d exp=11", i, as_cyc[i] - as_cyc[i-1]); end
    end
    checks++;
    if (rsp_cyc.size() != 1) begin failures++; $display("FAIL args_rsp_count got=%0d exp=1", rsp_cyc.size()); end
    else begin
      checks++;
      if ({rsp_d[0], rsp_e[0]} !== {8'h3C, 1'b0}) begin failures++; $display("FAIL args_rsp got=%h/%b exp=3c/0", rsp_d[0], rsp_e[0]); end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL args_strobe_overlap got=%0d exp=0", viol); end
  endtask

  task automatic test_busy_poll();
    logic [16:0] exp[7];
    exp = '{{1'b0, 8'h22, 8'h22}, {1'b0, 8'h28, 8'h81}, {1'b1, 8'h20, 8'h00}, {1'b1, 8'h20, 8'h00},
            {1'b1, 8'h20, 8'h00}, {1'b1, 8'h20, 8'h00}, {1'b1, 8'h21, 8'h00}};
    clear_log(); busy_left = 3; r1_val = 8'h5A;
    send(8'h81, 7'b0000010, 56'h22_00);
    wait_rsp(1);
    checks++;
    if (lg_addr.size() != 7) begin failures++; $display("FAIL poll_count got=%0d exp=7", lg_addr.size()); end
    for (int i = 0; i < 7 && i < lg_addr.size(); i++) begin
      checks++;
      if ({lg_rw[i], lg_addr[i], lg_rw[i] ? 8'h00 : lg_data[i]} !== exp[i]) begin
        failures++; $display("FAIL poll_access%0d got=%h exp=%h", i, {lg_rw[i], lg_addr[i], lg_rw[i] ? 8'h00 : lg_data[i]}, exp[i]);
      end
    end
    checks++;
    if (rsp_d.size() != 1 || rsp_d[0] !== 8'h5A) begin failures++; $display("FAIL poll_rsp_data got=%h exp=5a", sif.rsp_data); end
  endtask

  task automatic test_zero_mask();
    clear_log(); busy_left = 0; r1_val = 8'hC3;
    send(8'h00, 7'b0000000, 56'hFF_FF_FF_FF_FF_FF_FF);
    wait_rsp(1);
    checks++;
    if (lg_addr.size() != 3) begin failures++; $display("FAIL zero_count got=%0d exp=3", lg_addr.size()); end
    else begin
      checks++;
      if ({lg_rw[0], lg_addr[0], lg_data[0]} !== {1'b0, 8'h28, 8'h00}) begin
        failures++; $display("FAIL zero_first got=%h exp=02800", {lg_rw[0], lg_addr[0], lg_data[0]});
      end
    end
    checks++;
    if (sif.rsp_data !== 8'hC3) begin failures++; $display("FAIL zero_rsp_data got=%h exp=c3", sif.rsp_data); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_log(); busy_left = 0; r1_val = 8'h99;
    @(negedge clk_in);
    sif.req_valid = 1'b1; sif.req_cmd = 8'h44; sif.req_mask = '0; sif.req_args = '0;
    while (as_cyc.size() < 4 && n < 3000) begin @(negedge clk_in); n++; end
    sif.req_valid = 1'b0;
    checks++;
    if (n >= 3000) begin failures++; $display("FAIL b2b_second_start got=%0d exp=4", as_cyc.size()); end
    wait_rsp(2);
    repeat (60) @(negedge clk_in);
    checks++;
    if (lg_addr.size() != 6 || rsp_cyc.size() != 2) begin
      failures++; $display("FAIL b2b_counts strobes=%0d rsp=%0d exp strobes=6 rsp=2", lg_addr.size(), rsp_cyc.size());
    end
    else begin
      checks++;
      if (as_cyc[3] - rsp_cyc[0] != 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2", as_cyc[3] - rsp_cyc[0]); end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if ({lg_rw[i], lg_addr[i]} !== (i % 3 == 0 ? 9'h028 : i % 3 == 1 ? 9'h120 : 9'h121)) begin
          failures++; $display("FAIL b2b_access%0d got=%h", i, {lg_rw[i], lg_addr[i]});
        end
      end
      checks++;
      if ({rsp_d[1], rsp_e[1]} !== {8'h99, 1'b0}) begin failures++; $display("FAIL b2b_rsp got=%h/%b exp=99/0", rsp_d[1], rsp_e[1]); end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL b2b_strobe_overlap got=%0d exp=0", viol); end
  endtask

`ifdef EF9345_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int reads20 = 0, reads21 = 0;
    clear_log(); busy_left = 100000; r1_val = 8'h77;
    send(8'h55, 7'b0000000, 56'h0);
    wait_rsp(1);
    for (int i = 0; i < lg_addr.size(); i++) begin
      if (lg_rw[i] && lg_addr[i] == 8'h20) reads20++;
      if (lg_rw[i] && lg_addr[i] == 8'h21) reads21++;
    end
    checks++;
    if (reads20 != 4 || reads21 != 0) begin failures++; $display("FAIL tmo_reads got=%0d/%0d exp=4/0", reads20, reads21); end
    checks++;
    if (rsp_e.size() != 1 || rsp_e[0] !== 1'b1 || rsp_d[0] !== 8'h99) begin
      failures++; $display("FAIL tmo_rsp got err=%b data=%h exp err=1 data=99", sif.rsp_err, sif.rsp_data);
    end
    repeat (10) @(negedge clk_in);
    checks++;
    if (sif.rsp_err !== 1'b1) begin failures++; $display("FAIL tmo_err_held got=%b exp=1", sif.rsp_err); end
    busy_left = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_args_write();
    test_busy_poll();
    test_zero_mask();
    test_back_to_back();
`ifdef EF9345_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ef9345_cmd_seq.md
Name: ef9345_cmd_seq

Overview:
- Host-side sequencer that drives the EF9345 multiplexed bus (AS/DS/RW/CS_, 8-bit shared address/data) in Motorola mode.
- Accepts one command transaction at a time:
  - writes the selected argument registers R1..R7;
  - writes the command to R0 with the execute address;
  - polls the busy flag until it clears;
  - reads back R1 as the result.
- Sits between the VG5000 CPU-side glue/fill engine and the EF9345 bus pins.

Parameters:
- PHASE_CYC, 2, clk_in cycles per bus phase (≥1).
- ADDR_HI, 5'b00100, upper 5 bits of every address byte.
- BUSY_BIT, 7, bit of the R0 status read that signals busy.
- POLL_MAX, 255, maximum status polls before abort (only with the optional feature).

Ports:
- clk_in  in  1  system clock
- reset_  in  1  asynchronous, active-low reset
- req_valid  in  1  command request
- req_ready  out  1  sequencer idle; accepts the request this cycle
- req_cmd  in  8  value written to R0
- req_mask  in  7  bit i-1 set means write Ri (i=1..7)
- req_args  in  56  Ri at bits [8i-1:8i-8]
- rsp_valid  out  1  one-cycle pulse at end of transaction
- rsp_data  out  8  R1 read result
- rsp_err  out  1  poll timeout (0 when the feature is absent)
- bus_as  out  1  address strobe
- bus_ds  out  1  data strobe
- bus_rw  out  1  1 = read
- bus_cs_  out  1  chip select, active low
- bus_dout  out  8  address/data out
- bus_oe  out  1  drive bus_dout onto the pad
- bus_din  in  8  pad input

Behaviour:
- Reset values:
  - bus_as=0, bus_ds=0, bus_rw=1, bus_cs_=1, bus_oe=0, bus_dout=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1.
  - FSM in IDLE.
- Handshake:
  - Transfer occurs when req_valid && req_ready.
  - req_cmd, req_mask and req_args are captured that cycle; req_ready drops the next cycle.
- FSM states: IDLE → ARGS → CMD → POLL → RESULT → DONE → IDLE.
  - ARGS: one write per set mask bit, ascending R1→R7. A zero mask skips directly to CMD.
  - CMD: write req_cmd to R0 at the execute address {ADDR_HI,3'b000} | 8'h08.
  - POLL: read R0 at {ADDR_HI,3'b000}. If bus_din[BUSY_BIT]=1, issue another read immediately. If 0, go to RESULT.
  - RESULT: read R1 at {ADDR_HI,3'b001} and capture bus_din into rsp_data.
  - DONE: rsp_valid=1 for exactly one cycle, then IDLE with req_ready=1 the following cycle.
- Bus access: five phases, each held PHASE_CYC cycles. bus_cs_=0 through all five.
  - ADR: bus_as=1, bus_oe=1, bus_dout=address.
  - LAT: bus_as=0. The address stays driven; the chip latches it on the AS falling edge with DS=0 (Motorola mode).
  - SET:
    - Write: bus_oe=1, bus_dout=data, bus_rw=0.
    - Read: bus_oe=0, bus_rw=1.
  - STB: bus_ds=1.
    - Write: the chip stores data on the DS rising edge; data is held stable through STB.
    - Read: bus_din is sampled on the last cycle of STB.
  - HLD: bus_ds=0. Data is still driven for writes.
  - After HLD: bus_cs_=1, bus_oe=0, bus_rw=1 for one idle cycle between accesses.
- Access length: 5*PHASE_CYC+1 cycles. No two strobes overlap. bus_as and bus_ds are never 1 together.
- Phase counter: wraps 0..PHASE_CYC-1; the phase advances on wrap.
- Reset mid-transaction: all bus outputs return to reset values immediately (asynchronously). The transaction is dropped and no rsp_valid is produced.
- req_valid asserted while busy is ignored (not queued).

Optional Feature:
- Macro: EF9345_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit poll counter is cleared on entry to POLL and increments per completed status read.
  - Reaching POLL_MAX with busy still set goes to DONE with rsp_err=1, skips RESULT, and leaves rsp_data unchanged.
  - rsp_err is held until the next accepted request.
- Undefined: polling is unbounded and rsp_err is tied to 0.

Test Plan:
- Reset with PHASE_CYC=2, then assert reset_=0 mid-STB → all bus outputs at reset values in the same cycle; req_ready=1 after release.
- req_mask=7'b0000101, args R1=0x11, R3=0x33, cmd=0x80; model returns busy=0 → writes address/data 0x21/0x11, 0x23/0x33, 0x28/0x80; one read of 0x20, one read of 0x21; rsp_valid pulses once; each access is 11 cycles.
- Model holds busy=1 for 3 status reads → exactly 4 reads of 0x20 before the 0x21 read; rsp_data equals the model's R1 value (0x5A).
- Mask=0, cmd=0x00 → no argument writes; first access is the 0x28 write.
- req_valid held high through the transaction → second transaction starts only after DONE+1; no lost or duplicated strobes.
- With EF9345_SEQ_TIMEOUT_EN and POLL_MAX=4, model busy forever → 4 status reads, rsp_valid with rsp_err=1, no 0x21 read.
